// File: rtl/debounce_pkg.sv
// debounce_pkg: shared defaults and counter type for the key debouncer array
package debounce_pkg;
  localparam int N_KEYS_DEF = 4;
  localparam int CNT_W_DEF = 16;
  localparam int LONG_W_DEF = 24;
  localparam bit ACTIVE_LOW_DEF = 1'b1;
  typedef logic [CNT_W_DEF-1:0] cnt_t;
endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one key channel -- 2-flop sync, stability counter, debounced level and edge pulses
// Ports: clk, rst (sync, active-high), key_i raw pin, key_state_o debounced level (1 = pressed),
// press_o / release_o one-cycle edge pulses, long_press_o one-cycle hold pulse.
// Long-press counting exists only when DEBOUNCE_LONG_PRESS_EN is defined; otherwise long_press_o is 0.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter bit ACTIVE_LOW = ACTIVE_LOW_DEF,
  parameter int LONG_W = LONG_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic key_state_o,
  output logic press_o,
  output logic release_o,
  output logic long_press_o
);
  logic s1_q, s_q, key_state_q, key_state_d, press_q, press_d, release_q, release_d, diff, flip;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // the counter saturating at all-ones is the "stable long enough" condition; it clears instead of wrapping
  always_comb begin
    diff = s_q ^ key_state_q;
    flip = diff & (&cnt_q);
    cnt_d = (diff && !flip) ? cnt_q + 1'b1 : '0;
    key_state_d = key_state_q ^ flip;
    press_d = flip & ~key_state_q;
    release_d = flip & key_state_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      s1_q <= 1'b0;
      s_q <= 1'b0;
      cnt_q <= '0;
      key_state_q <= 1'b0;
      press_q <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q <= key_i ^ ACTIVE_LOW;
      s_q <= s1_q;
      cnt_q <= cnt_d;
      key_state_q <= key_state_d;
      press_q <= press_d;
      release_q <= release_d;
    end
  assign key_state_o = key_state_q;
  assign press_o = press_q;
  assign release_o = release_q;
`ifdef DEBOUNCE_LONG_PRESS_EN
  logic [LONG_W-1:0] lcnt_q, lcnt_d;
  logic long_q, long_d, held;
  // held excludes the release edge so a release landing on the threshold cycle never pulses
  always_comb begin
    held = key_state_q & key_state_d;
    lcnt_d = !held ? '0 : (&lcnt_q) ? lcnt_q : lcnt_q + 1'b1;
    long_d = held && (lcnt_q == ~LONG_W'(1));
  end
  always_ff @(posedge clk)
    if (rst) begin
      lcnt_q <= '0;
      long_q <= 1'b0;
    end else begin
      lcnt_q <= lcnt_d;
      long_q <= long_d;
    end
  assign long_press_o = long_q;
`else
  logic unused_long;
  assign unused_long = ^LONG_W;
  assign long_press_o = 1'b0;
`endif
endmodule

// File: rtl/debouncer_array.sv
// debouncer_array: N_KEYS independent debounced key channels with press/release/long-press pulses
// Ports: clk, rst (sync, active-high), key_i raw pins, key_state_o debounced levels,
// press_o / release_o / long_press_o per-key pulses, any_pressed_o OR of all levels.
// Optional feature macro: DEBOUNCE_LONG_PRESS_EN.
module debouncer_array
  import debounce_pkg::*;
#(
  parameter int N_KEYS = N_KEYS_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter bit ACTIVE_LOW = ACTIVE_LOW_DEF,
  parameter int LONG_W = LONG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_i,
  output logic [N_KEYS-1:0] key_state_o,
  output logic [N_KEYS-1:0] press_o,
  output logic [N_KEYS-1:0] release_o,
  output logic              any_pressed_o,
  output logic [N_KEYS-1:0] long_press_o
);
  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    debounce_chan #(
      .CNT_W(CNT_W),
      .ACTIVE_LOW(ACTIVE_LOW),
      .LONG_W(LONG_W)
    ) u_chan (
      .clk(clk),
      .rst(rst),
      .key_i(key_i[i]),
      .key_state_o(key_state_o[i]),
      .press_o(press_o[i]),
      .release_o(release_o[i]),
      .long_press_o(long_press_o[i])
    );
  end
  assign any_pressed_o = |key_state_o;
endmodule

// File: tb/tb_debouncer_array.sv
// tb_debouncer_array: randomized + directed check of debouncer_array against a window-based model
module tb_debouncer_array;
  localparam int NK = 4;
  localparam int CW = 4;
  localparam int LW = 6;
  localparam int STAB = 1 << CW;
  localparam int LONGN = (1 << LW) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NK-1:0] key = '1;
  logic [NK-1:0] key_state, press, rel, long_press;
  logic any_pressed;
  int checks = 0;
  int fails = 0;
  debouncer_array #(.N_KEYS(NK), .CNT_W(CW), .ACTIVE_LOW(1'b1), .LONG_W(LW)) dut (
    .clk(clk),
    .rst(rst),
    .key_i(key),
    .key_state_o(key_state),
    .press_o(press),
    .release_o(rel),
    .any_pressed_o(any_pressed),
    .long_press_o(long_press)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Model: hist[m] is the post-polarity sample taken at edge m; the synchroniser presents it at edge m+2.
  // A channel toggles at edge n when the last STAB synchronised samples all disagree with the level
  // and that whole window lies after the previous toggle or reset.
  logic [NK-1:0] hist [0:16383];
  int last [NK];
  int n = 0;
  logic [NK-1:0] m_ks = '0, m_pr = '0, m_rl = '0, m_lp = '0;
  always @(posedge clk) begin
    n++;
    hist[n] = rst ? '0 : ~key;
    if (rst) begin
      hist[n-1] = '0;
      for (int i = 0; i < NK; i++) last[i] = n;
      m_ks = '0; m_pr = '0; m_rl = '0; m_lp = '0;
    end else begin
      for (int i = 0; i < NK; i++) begin
        bit tog, nw;
        tog = (n - (STAB - 1)) > last[i];
        if (tog)
          for (int j = 0; j < STAB; j++)
            if (hist[n-2-j][i] == m_ks[i]) tog = 1'b0;
        nw = m_ks[i] ^ tog;
        m_pr[i] = tog & nw;
        m_rl[i] = tog & ~nw;
`ifdef DEBOUNCE_LONG_PRESS_EN
        m_lp[i] = m_ks[i] & nw & ((n - last[i]) == LONGN);
`else
        m_lp[i] = 1'b0;
`endif
        if (tog) last[i] = n;
        m_ks[i] = nw;
      end
    end
  end
  always @(negedge clk)
    if (n > 0) begin
      chk("key_state", key_state, m_ks);
      chk("press", press, m_pr);
      chk("release", rel, m_rl);
      chk("any_pressed", any_pressed, |m_ks);
      chk("long_press", long_press, m_lp);
      if (press & rel) chk("press_and_release", press & rel, 0);
    end
  task automatic wait_pulse(input int ch, input int kind, output int c);
    c = -1;
    for (int k = 1; k <= 150; k++) begin
      @(posedge clk); #1;
      if ((kind == 0 && press[ch]) || (kind == 1 && rel[ch]) || (kind == 2 && long_press[ch])) begin
        c = k;
        break;
      end
    end
  endtask
  initial begin
    int c;
    bit seen;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_key_state", key_state, 0);
    chk("reset_any", any_pressed, 0);
    repeat (5) @(posedge clk);
    #1 chk("idle_no_press", press, 0);
    key[0] = 1'b0;
    wait_pulse(0, 0, c);
    chk("press0_latency", c, 18);
    chk("press0_level", key_state[0], 1);
    @(posedge clk); #1 chk("press0_one_cycle", press[0], 0);
`ifdef DEBOUNCE_LONG_PRESS_EN
    wait_pulse(0, 2, c);
    chk("long0_latency", c + 1, 63);
    @(posedge clk); #1 chk("long0_single", long_press[0], 0);
    repeat (30) @(posedge clk);
`else
    repeat (100) @(posedge clk);
    #1 chk("long0_tied", long_press, 0);
`endif
    key[0] = 1'b1;
    wait_pulse(0, 1, c);
    chk("release0_latency", c, 18);
    chk("release0_any", any_pressed, 0);
    seen = 1'b0;
    repeat (6) begin
      key[1] = 1'b0;
      repeat (10) begin @(posedge clk); #1 seen |= press[1]; end
      key[1] = 1'b1;
      @(posedge clk); #1 seen |= press[1];
    end
    repeat (20) begin @(posedge clk); #1 seen |= press[1]; end
    chk("glitch1_no_press", seen, 0);
    chk("glitch1_state", key_state[1], 0);
    key[3:2] = 2'b00;
    wait_pulse(2, 0, c);
    chk("press2_latency", c, 18);
    chk("press3_together", press[3], 1);
    chk("any_after_23", any_pressed, 1);
    key[3:2] = 2'b11;
    repeat (25) @(posedge clk);
    #1 key[0] = 1'b0;
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1 seen |= press[0]; end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    seen |= press[0];
    wait_pulse(0, 0, c);
    chk("rst_mid_no_early_press", seen, 0);
    chk("rst_mid_press_latency", c, 18);
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NK; i++)
        if ($urandom_range(0, 15) == 0) key[i] = ~key[i];
      rst = ($urandom_range(0, 599) == 0);
    end
    rst = 1'b0;
    key = '1;
    repeat (40) @(posedge clk);
    #1 chk("final_idle", key_state, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
